// File: rtl/mdec_pixel_packer_pkg.sv
// rtl/mdec_pixel_packer_pkg.sv - shared constants, types and helpers for the MDEC pixel packer
package mdec_pixel_packer_pkg;

    localparam int PIX_MONO    = 64;
    localparam int PIX_COL     = 256;
    localparam int WORDS_4BIT  = 8;
    localparam int WORDS_8BIT  = 16;
    localparam int WORDS_15BIT = 128;
    localparam int WORDS_24BIT = 192;

    typedef enum logic [1:0] {
        DEPTH_4  = 2'd0,
        DEPTH_8  = 2'd1,
        DEPTH_24 = 2'd2,
        DEPTH_15 = 2'd3
    } depth_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_WAIT,
        S_HOLD
    } drain_state_t;

    function automatic logic is_mono(depth_t d);
        return ~d[1];
    endfunction

    function automatic logic [8:0] block_pixels(depth_t d);
        return is_mono(d) ? 9'(PIX_MONO) : 9'(PIX_COL);
    endfunction

    function automatic logic [7:0] block_words(depth_t d);
        logic [7:0] n;
        case (d)
            DEPTH_4:  n = 8'(WORDS_4BIT);
            DEPTH_8:  n = 8'(WORDS_8BIT);
            DEPTH_15: n = 8'(WORDS_15BIT);
            default:  n = 8'(WORDS_24BIT);
        endcase
        return n;
    endfunction

    // True when the pixel at idx is the one that completes a 32-bit word
    function automatic logic closes_word(depth_t d, logic [7:0] idx);
        logic c;
        case (d)
            DEPTH_4:  c = (idx[2:0] == 3'd7);
            DEPTH_8:  c = (idx[1:0] == 2'd3);
            DEPTH_15: c = idx[0];
            default:  c = (idx[1:0] != 2'd0);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mdec_pixel_packer_if.sv
// rtl/mdec_pixel_packer_if.sv - pixel input stream and packed word output handshake
interface mdec_pixel_packer_if;
    logic [1:0]  i_bitSetupDepth;
    logic        i_bit15;
    logic        i_pixelWrt;
    logic [7:0]  i_pixelAddress;
    logic [7:0]  i_r;
    logic [7:0]  i_g;
    logic [7:0]  i_b;
    logic        o_stall;
    logic        o_wordValid;
    logic        i_wordReady;
    logic [31:0] o_word;
    logic        o_lastWord;

    modport slave (
        input  i_bitSetupDepth, i_bit15, i_pixelWrt, i_pixelAddress, i_r, i_g, i_b, i_wordReady,
        output o_stall, o_wordValid, o_word, o_lastWord
    );

    modport master (
        output i_bitSetupDepth, i_bit15, i_pixelWrt, i_pixelAddress, i_r, i_g, i_b, i_wordReady,
        input  o_stall, o_wordValid, o_word, o_lastWord
    );
endinterface

// File: rtl/mdec_pixel_packer_pack_unit.sv
// rtl/mdec_pixel_packer_pack_unit.sv - accumulates pixels LSB-first into 32-bit words
module mdec_pixel_packer_pack_unit
    import mdec_pixel_packer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  depth_t      depth,
    input  logic        bit15,
    input  logic        pix_valid,
    input  logic [23:0] pix,
    output logic        word_rdy,
    output logic [31:0] word
);

    logic [31:0] acc;
    logic [31:0] acc_nx;
    logic [31:0] word_nx;
    logic [2:0]  slot;
    logic [2:0]  slot_nx;
    logic        done;
    logic [15:0] p15;
    logic [23:0] bytes24;
    logic [55:0] wide;

    assign p15     = {bit15, pix[7:3], pix[15:11], pix[23:19]};
    assign bytes24 = {pix[7:0], pix[15:8], pix[23:16]};
    // 24-bit pixels straddle words; the upper part of wide carries into the next word
    assign wide    = {24'd0, acc} | ({32'd0, bytes24} << {slot[1:0], 3'b000});

    always_comb begin
        word_nx = acc;
        acc_nx  = acc;
        done    = 1'b0;
        slot_nx = slot + 3'd1;
        case (depth)
            DEPTH_4: begin
                word_nx = acc | ({28'd0, pix[23:20]} << {slot, 2'b00});
                done    = (slot == 3'd7);
            end
            DEPTH_8: begin
                word_nx = acc | ({24'd0, pix[23:16]} << {slot[1:0], 3'b000});
                done    = (slot[1:0] == 2'd3);
            end
            DEPTH_15: begin
                word_nx = acc | ({16'd0, p15} << {slot[0], 4'b0000});
                done    = slot[0];
            end
            default: begin
                word_nx = wide[31:0];
                done    = (slot[1:0] != 2'd0);
                slot_nx = {1'b0, slot[1:0] - 2'd1};
            end
        endcase
        if (done) begin
            acc_nx = (depth == DEPTH_24) ? {8'd0, wide[55:32]} : 32'd0;
            if (depth != DEPTH_24)
                slot_nx = 3'd0;
        end else begin
            acc_nx = word_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= 32'd0;
            slot     <= 3'd0;
            word_rdy <= 1'b0;
            word     <= 32'd0;
        end else if (clear) begin
            acc      <= 32'd0;
            slot     <= 3'd0;
            word_rdy <= 1'b0;
        end else begin
            word_rdy <= pix_valid && done;
            if (pix_valid) begin
                acc  <= acc_nx;
                slot <= slot_nx;
                if (done)
                    word <= word_nx;
            end
        end
    end

endmodule

// File: rtl/mdec_pixel_packer.sv
// rtl/mdec_pixel_packer.sv - ping-pong block buffer that drains MDEC pixels as packed 32-bit words
module mdec_pixel_packer
    import mdec_pixel_packer_pkg::*;
(
    input  logic          clk,
    input  logic          i_rst,
    mdec_pixel_packer_if.slave bus
);

    logic [23:0]  mem [0:511];
    logic [1:0]   bank_full;
    depth_t       bank_depth [2];
    logic         fill_bank;
    logic         drain_bank;
    logic [8:0]   fill_cnt;
    depth_t       fill_depth;
    logic [7:0]   wr_idx;
    logic         wr_en;
    logic         fill_done;

    drain_state_t state;
    drain_state_t state_nx;
    depth_t       drain_depth;
    logic [7:0]   rd_idx;
    logic         rd_en;
    logic         rd_vld;
    logic [23:0]  rd_data;
    logic [7:0]   word_cnt;
    logic         last_word;
    logic         pack_clear;
    logic         pack_rdy;
    logic [31:0]  pack_word;
    logic         load_word;
    logic         accept;
    logic         release_bank;
    logic [31:0]  word_q;

    assign bus.o_stall = bank_full[fill_bank];
    assign wr_en       = bus.i_pixelWrt && !bank_full[fill_bank];
    // The bank's format is fixed by its first pixel; later pixels reuse the latched depth
    assign fill_depth  = (fill_cnt == 9'd0) ? depth_t'(bus.i_bitSetupDepth) : bank_depth[fill_bank];
    assign wr_idx      = is_mono(fill_depth)
                       ? {2'b00, bus.i_pixelAddress[6:4], bus.i_pixelAddress[2:0]}
                       : bus.i_pixelAddress;
    assign fill_done   = wr_en && ((fill_cnt + 9'd1) == block_pixels(fill_depth));

    assign drain_depth = bank_depth[drain_bank];
    assign last_word   = (word_cnt == block_words(drain_depth) - 8'd1);

    assign bus.o_wordValid = (state == S_HOLD);
    assign bus.o_lastWord  = (state == S_HOLD) && last_word;
    assign bus.o_word      = word_q;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{fill_bank, wr_idx}] <= {bus.i_r, bus.i_g, bus.i_b};
        rd_data <= mem[{drain_bank, rd_idx}];
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            bank_full     <= 2'b00;
            fill_bank     <= 1'b0;
            drain_bank    <= 1'b0;
            fill_cnt      <= 9'd0;
            bank_depth[0] <= DEPTH_4;
            bank_depth[1] <= DEPTH_4;
        end else begin
            if (release_bank) begin
                bank_full[drain_bank] <= 1'b0;
                drain_bank            <= ~drain_bank;
            end
            if (wr_en) begin
                if (fill_cnt == 9'd0)
                    bank_depth[fill_bank] <= depth_t'(bus.i_bitSetupDepth);
                if (fill_done) begin
                    bank_full[fill_bank] <= 1'b1;
                    fill_cnt             <= 9'd0;
                    fill_bank            <= ~fill_bank;
                end else begin
                    fill_cnt <= fill_cnt + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Reads stop after the word-closing pixel so the accumulator never holds more than one word
    always_comb begin
        state_nx     = state;
        rd_en        = 1'b0;
        pack_clear   = 1'b0;
        load_word    = 1'b0;
        accept       = 1'b0;
        release_bank = 1'b0;
        case (state)
            S_IDLE: begin
                pack_clear = 1'b1;
                if (bank_full[drain_bank])
                    state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                rd_en = 1'b1;
                if (closes_word(drain_depth, rd_idx))
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (pack_rdy) begin
                    load_word = 1'b1;
                    state_nx  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.i_wordReady) begin
                    accept = 1'b1;
                    if (last_word) begin
                        release_bank = 1'b1;
                        state_nx     = S_IDLE;
                    end else begin
                        state_nx = S_DRAIN;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            rd_idx   <= 8'd0;
            rd_vld   <= 1'b0;
            word_cnt <= 8'd0;
            word_q   <= 32'd0;
        end else begin
            rd_vld <= rd_en;
            if (state == S_IDLE) begin
                rd_idx   <= 8'd0;
                word_cnt <= 8'd0;
            end else begin
                if (rd_en)
                    rd_idx <= rd_idx + 8'd1;
                if (accept)
                    word_cnt <= word_cnt + 8'd1;
            end
            if (load_word)
                word_q <= pack_word;
        end
    end

    mdec_pixel_packer_pack_unit u_pack (
        .clk      (clk),
        .rst      (i_rst),
        .clear    (pack_clear),
        .depth    (drain_depth),
        .bit15    (bus.i_bit15),
        .pix_valid(rd_vld),
        .pix      (rd_data),
        .word_rdy (pack_rdy),
        .word     (pack_word)
    );

    a_no_write_on_stall: assert property (@(posedge clk) disable iff (i_rst)
        !(bus.i_pixelWrt && bus.o_stall));

endmodule

// File: tb/tb_mdec_pixel_packer.sv
// tb/tb_mdec_pixel_packer.sv - directed self-checking bench for mdec_pixel_packer
module tb_mdec_pixel_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdec_pixel_packer_if bus();

    mdec_pixel_packer dut (
        .clk  (clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] words [0:255];
    int          nwords;
    int          last_at;
    logic        stall_last;
    logic        stall_post;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bus.i_pixelWrt     = 1'b1;
        bus.i_pixelAddress = a;
        bus.i_r            = r;
        bus.i_g            = g;
        bus.i_b            = b;
        @(posedge clk); #1;
        bus.i_pixelWrt     = 1'b0;
    endtask

    task automatic fill_mono8;
        for (int i = 0; i < 64; i++)
            put(8'(((i / 8) << 4) | (i % 8)), 8'(i), 8'd0, 8'd0);
    endtask

    task automatic collect(input int budget, input bit toggle);
        int c   = 0;
        bit fin = 0;
        nwords = 0; last_at = -1; stall_last = 1'b0; stall_post = 1'b0;
        while (c < budget && !fin) begin
            bus.i_wordReady = toggle ? c[0] : 1'b1;
            if (bus.o_wordValid && bus.i_wordReady) begin
                if (nwords < 256) words[nwords] = bus.o_word;
                if (bus.o_lastWord) begin
                    last_at = nwords;
                    stall_last = bus.o_stall;
                    fin = 1;
                end
                nwords++;
            end
            @(posedge clk); #1;
            if (fin) stall_post = bus.o_stall;
            c++;
        end
        bus.i_wordReady = 1'b0;
    endtask

    initial begin
        int bad;
        int n;
        logic [31:0] e;
        bus.i_bitSetupDepth = 2'd0; bus.i_bit15 = 1'b0; bus.i_pixelWrt = 1'b0;
        bus.i_pixelAddress = 8'd0; bus.i_r = 8'd0; bus.i_g = 8'd0; bus.i_b = 8'd0;
        bus.i_wordReady = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(bus.o_stall), 32'd0);
        chk("rst_valid", 32'(bus.o_wordValid), 32'd0);
        chk("rst_word", bus.o_word, 32'd0);
        chk("rst_last", 32'(bus.o_lastWord), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Mono 8bit raster block
        bus.i_bitSetupDepth = 2'd1;
        fill_mono8();
        chk("m8_stall_after_fill", 32'(bus.o_stall), 32'd0);
        collect(2000, 1'b0);
        chk("m8_count", 32'(nwords), 32'd16);
        chk("m8_word0", words[0], 32'h03020100);
        chk("m8_word15", words[15], 32'h3F3E3D3C);
        chk("m8_last_pos", 32'(last_at), 32'd15);
        bad = 0;
        for (int w = 0; w < 16; w++) begin
            e = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            if (words[w] !== e) bad++;
        end
        chk("m8_all_words_bad", 32'(bad), 32'd0);

        // Mono 4bit
        bus.i_bitSetupDepth = 2'd0;
        for (int i = 0; i < 64; i++)
            put(8'(((i / 8) << 4) | (i % 8)), 8'(i << 4), 8'd0, 8'd0);
        collect(2000, 1'b0);
        chk("m4_count", 32'(nwords), 32'd8);
        chk("m4_word0", words[0], 32'h76543210);
        chk("m4_word1", words[1], 32'hFEDCBA98);
        chk("m4_word7", words[7], 32'hFEDCBA98);
        chk("m4_last_pos", 32'(last_at), 32'd7);

        // Colour 15bit, constant pixel
        bus.i_bitSetupDepth = 2'd3; bus.i_bit15 = 1'b1;
        for (int k = 0; k < 256; k++)
            put(8'(k), 8'hF8, 8'h00, 8'h08);
        collect(4000, 1'b0);
        chk("c15_count", 32'(nwords), 32'd128);
        bad = 0;
        for (int w = 0; w < 128; w++)
            if (words[w] !== 32'h841F841F) bad++;
        chk("c15_all_words_bad", 32'(bad), 32'd0);
        chk("c15_last_pos", 32'(last_at), 32'd127);

        // Colour 24bit, straddling pixels
        bus.i_bitSetupDepth = 2'd2;
        for (int k = 0; k < 256; k++)
            put(8'(k), 8'(k), 8'(k + 1), 8'(k + 2));
        collect(6000, 1'b0);
        chk("c24_count", 32'(nwords), 32'd192);
        chk("c24_word0", words[0], 32'h01020100);
        chk("c24_word1", words[1], 32'h03020302);
        chk("c24_word2", words[2], 32'h05040304);
        chk("c24_word191", words[191], 32'h0100FF00);
        chk("c24_last_pos", 32'(last_at), 32'd191);

        // Backpressure: two 15bit blocks with no drain
        bus.i_bitSetupDepth = 2'd3; bus.i_bit15 = 1'b1; bus.i_wordReady = 1'b0;
        for (int k = 0; k < 512; k++)
            put(8'(k), 8'(k * 8), 8'd0, 8'd0);
        chk("bp_stall_full", 32'(bus.o_stall), 32'd1);
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_valid", 32'(bus.o_wordValid), 32'd1);
            chk("bp_hold_word", bus.o_word, 32'h80018000);
            @(posedge clk); #1;
        end
        collect(8000, 1'b1);
        chk("bp_b1_count", 32'(nwords), 32'd128);
        bad = 0;
        for (int w = 0; w < 128; w++) begin
            e = 32'h80008000 | (32'((2*w+1) % 32) << 16) | 32'((2*w) % 32);
            if (words[w] !== e) bad++;
        end
        chk("bp_b1_words_bad", 32'(bad), 32'd0);
        chk("bp_stall_at_last", 32'(stall_last), 32'd1);
        chk("bp_stall_after_last", 32'(stall_post), 32'd0);
        collect(8000, 1'b1);
        chk("bp_b2_count", 32'(nwords), 32'd128);
        bad = 0;
        for (int w = 0; w < 128; w++) begin
            e = 32'h80008000 | (32'((2*w+1) % 32) << 16) | 32'((2*w) % 32);
            if (words[w] !== e) bad++;
        end
        chk("bp_b2_words_bad", 32'(bad), 32'd0);

        // Reset while word 50 is being presented
        for (int k = 0; k < 256; k++)
            put(8'(k), 8'(k * 8), 8'd0, 8'd0);
        n = 0;
        for (int c = 0; c < 4000 && !(bus.o_wordValid && n == 50); c++) begin
            bus.i_wordReady = 1'b0;
            if (bus.o_wordValid) begin
                bus.i_wordReady = 1'b1;
                n++;
            end
            @(posedge clk); #1;
        end
        bus.i_wordReady = 1'b0;
        chk("rm_reached_word50", 32'(n), 32'd50);
        chk("rm_word50", bus.o_word, 32'h80058004);
        #2 rst = 1'b1;
        #1;
        chk("rm_valid_async", 32'(bus.o_wordValid), 32'd0);
        chk("rm_stall_async", 32'(bus.o_stall), 32'd0);
        chk("rm_word_async", bus.o_word, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.i_bitSetupDepth = 2'd1;
        fill_mono8();
        collect(2000, 1'b0);
        chk("rm_count", 32'(nwords), 32'd16);
        chk("rm_word0", words[0], 32'h03020100);
        chk("rm_word15", words[15], 32'h3F3E3D3C);
        chk("rm_last_pos", 32'(last_at), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
